// File: rtl/beat_clock_multi_if.sv
// beat_clock_multi_if: board-side bundle for the multi-player beat-the-clock game.
// Ports (master = board/decoder side, slave = game core):
//   start       level request to begin a game (master -> slave)
//   player_in   player p's switches at [p*WIDTH +: WIDTH] (master -> slave)
//   target      value the active player must match (slave -> master)
//   timers      player p's seconds left at [p*TW +: TW] (slave -> master)
//   active      index of the player whose clock runs (slave -> master)
//   alive       bit p set while player p is still in the game (slave -> master)
//   running     game in progress (slave -> master)
//   game_over   game finished, winner valid (slave -> master)
//   winner      index of the last survivor (slave -> master)
//   match_pulse one-cycle strobe per accepted match (slave -> master)
interface beat_clock_multi_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int WIDTH = 5,
    parameter int START_SECONDS = 30
);
    localparam int TW = $clog2(START_SECONDS + 1);
    localparam int PW = NUM_PLAYERS > 2 ? $clog2(NUM_PLAYERS) : 1;
    logic start;
    logic [NUM_PLAYERS*WIDTH-1:0] player_in;
    logic [WIDTH-1:0] target;
    logic [NUM_PLAYERS*TW-1:0] timers;
    logic [PW-1:0] active;
    logic [NUM_PLAYERS-1:0] alive;
    logic running;
    logic game_over;
    logic [PW-1:0] winner;
    logic match_pulse;
    modport master (
        output start, player_in,
        input target, timers, active, alive, running, game_over, winner, match_pulse
    );
    modport slave (
        input start, player_in,
        output target, timers, active, alive, running, game_over, winner, match_pulse
    );
endinterface

// File: rtl/beat_clock_multi.sv
// beat_clock_multi: N-player binary-match countdown game core; raw binary state out.
// Ports:
//   clk    system clock
//   reset  synchronous active-high, clears all state
//   bus    beat_clock_multi_if.slave (start, player_in in; target, timers, active,
//          alive, running, game_over, winner, match_pulse out)
// Optional feature: define BEAT_CLOCK_BONUS_EN to add BONUS_SECONDS (saturating at
// START_SECONDS) to the outgoing player's timer on every accepted match.
module beat_clock_multi #(
    parameter int NUM_PLAYERS = 2,
    parameter int WIDTH = 5,
    parameter int START_SECONDS = 30,
    parameter int TICK_DIV = 50000000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int BONUS_SECONDS = 2
) (
    input logic clk,
    input logic reset,
    beat_clock_multi_if.slave bus
);
    localparam int TW = $clog2(START_SECONDS + 1);
    localparam int PW = NUM_PLAYERS > 2 ? $clog2(NUM_PLAYERS) : 1;
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
`ifdef BEAT_CLOCK_BONUS_EN
    localparam int BONUS = BONUS_SECONDS;
`else
    // A zero bonus makes the saturating add below an identity.
    localparam int BONUS = 0 * BONUS_SECONDS;
`endif
    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
    state_t state, state_nx;
    logic [15:0] lfsr;
    logic [CW-1:0] cnt;
    logic [NUM_PLAYERS*TW-1:0] timers;
    logic [NUM_PLAYERS-1:0] alive;
    logic [PW-1:0] active, winner, succ;
    logic [WIDTH-1:0] target, fresh;
    logic [TW-1:0] cur_t, boosted;
    logic match_pulse, tick, match, expire, last;
    assign tick = state == RUN && cnt == CW'(TICK_DIV - 1);
    assign cur_t = timers[active*TW +: TW];
    assign match = state == RUN && bus.player_in[active*WIDTH +: WIDTH] == target;
    assign expire = tick && !match && cur_t == TW'(1);
    assign last = expire && $countones(alive) == 2;
    // Inverting the LSB on a repeat guarantees a held input never matches twice.
    assign fresh = lfsr[WIDTH-1:0] ^ WIDTH'(lfsr[WIDTH-1:0] == target);
    assign boosted = (int'(cur_t) + BONUS >= START_SECONDS) ? TW'(START_SECONDS) : cur_t + TW'(BONUS);
    // Nearest surviving player after the active one, wrapping around.
    always_comb begin
        succ = active;
        for (int k = NUM_PLAYERS - 1; k >= 1; k--)
            if (alive[(int'(active) + k) % NUM_PLAYERS]) succ = PW'((int'(active) + k) % NUM_PLAYERS);
    end
    always_ff @(posedge clk)
        if (reset) state <= IDLE;
        else state <= state_nx;
    always_comb
        state_nx = state == IDLE ? (bus.start ? RUN : IDLE) : state == RUN ? (last ? OVER : RUN) : OVER;
    always_comb begin
        bus.running = state == RUN;
        bus.game_over = state == OVER;
    end
    always_ff @(posedge clk)
        if (reset) lfsr <= LFSR_SEED;
        else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    always_ff @(posedge clk) begin
        if (reset) begin
            timers <= {NUM_PLAYERS{TW'(START_SECONDS)}};
            alive <= '1;
            active <= '0;
            winner <= '0;
            target <= LFSR_SEED[WIDTH-1:0];
            match_pulse <= 1'b0;
            cnt <= '0;
        end else begin
            match_pulse <= match;
            if (state == IDLE && bus.start) begin
                active <= '0;
                cnt <= '0;
                target <= lfsr[WIDTH-1:0];
            end else if (state == RUN) begin
                cnt <= tick ? '0 : cnt + 1'b1;
                // A match on a tick cycle swallows that tick.
                if (match) begin
                    active <= succ;
                    target <= fresh;
                    timers[active*TW +: TW] <= boosted;
                end else if (tick) begin
                    timers[active*TW +: TW] <= cur_t - TW'(cur_t != '0);
                    if (expire) begin
                        alive[active] <= 1'b0;
                        if (last) winner <= succ;
                        else begin
                            active <= succ;
                            target <= fresh;
                        end
                    end
                end
            end
        end
    end
    assign bus.target = target;
    assign bus.timers = timers;
    assign bus.active = active;
    assign bus.alive = alive;
    assign bus.winner = winner;
    assign bus.match_pulse = match_pulse;
endmodule

// File: tb/tb_beat_clock_multi.sv
// tb_beat_clock_multi: randomized and directed check of beat_clock_multi against a behavioural game model.
module tb_beat_clock_multi;
    localparam int NP = 3;
    localparam int W = 5;
    localparam int SS = 5;
    localparam int TD = 4;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int TW = $clog2(SS + 1);
    localparam int PIW = NP * W;
`ifdef BEAT_CLOCK_BONUS_EN
    localparam int BON = 2;
`else
    localparam int BON = 0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    beat_clock_multi_if #(.NUM_PLAYERS(NP), .WIDTH(W), .START_SECONDS(SS)) bus ();
    beat_clock_multi #(
        .NUM_PLAYERS(NP), .WIDTH(W), .START_SECONDS(SS), .TICK_DIV(TD),
        .LFSR_SEED(SEED), .BONUS_SECONDS(2)
    ) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    logic [15:0] m_lfsr;
    int m_phase;
    int m_t[NP];
    logic [NP-1:0] m_alive;
    int m_act, m_win, m_rc;
    logic [W-1:0] m_tgt;
    logic m_mp;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic int next_alive(input int from);
        for (int k = 1; k < NP; k++)
            if (m_alive[(from + k) % NP]) return (from + k) % NP;
        return from;
    endfunction

    task automatic model_step();
        logic [15:0] cur;
        logic [W-1:0] nt;
        bit hit, tk;
        if (reset) begin
            m_lfsr = SEED;
            m_phase = 0;
            for (int p = 0; p < NP; p++) m_t[p] = SS;
            m_alive = '1;
            m_act = 0;
            m_win = 0;
            m_rc = 0;
            m_tgt = SEED[W-1:0];
            m_mp = 1'b0;
            return;
        end
        cur = m_lfsr;
        m_lfsr = lfsr_next(m_lfsr);
        m_mp = 1'b0;
        if (m_phase == 0) begin
            if (bus.start) begin
                m_phase = 1;
                m_rc = 0;
                m_act = 0;
                m_tgt = cur[W-1:0];
            end
        end else if (m_phase == 1) begin
            hit = bus.player_in[m_act*W +: W] == m_tgt;
            tk = (m_rc % TD) == TD - 1;
            m_rc++;
            nt = cur[W-1:0];
            if (nt == m_tgt) nt[0] = ~nt[0];
            if (hit) begin
                m_mp = 1'b1;
                m_t[m_act] = (m_t[m_act] + BON > SS) ? SS : m_t[m_act] + BON;
                m_act = next_alive(m_act);
                m_tgt = nt;
            end else if (tk) begin
                m_t[m_act] = m_t[m_act] - 1;
                if (m_t[m_act] == 0) begin
                    m_alive[m_act] = 1'b0;
                    if ($countones(m_alive) == 1) begin
                        m_phase = 2;
                        m_win = next_alive(m_act);
                    end else begin
                        m_act = next_alive(m_act);
                        m_tgt = nt;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_safe();
        bus.player_in = {NP{~m_tgt}};
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("target", 32'(bus.target), 32'(m_tgt));
            for (int p = 0; p < NP; p++) chk("timer", 32'(bus.timers[p*TW +: TW]), m_t[p]);
            chk("alive", 32'(bus.alive), 32'(m_alive));
            chk("active", 32'(bus.active), m_act);
            chk("running", 32'(bus.running), 32'(m_phase == 1));
            chk("game_over", 32'(bus.game_over), 32'(m_phase == 2));
            chk("match_pulse", 32'(bus.match_pulse), 32'(m_mp));
            if (m_phase == 2) chk("winner", 32'(bus.winner), m_win);
        end
    end

    initial begin
        logic [W-1:0] old;
        bus.start = 1'b0;
        bus.player_in = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_target", 32'(bus.target), 32'd1);
        chk("rst_timers", 32'(bus.timers), 32'({3{3'd5}}));
        chk("rst_alive", 32'(bus.alive), 32'b111);
        chk("rst_running", 32'(bus.running), 32'd0);
        // Timeout scenario: nobody ever matches.
        reset = 1'b0;
        bus.start = 1'b1;
        drive_safe();
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_target", 32'(bus.target), 32'd1);
        chk("start_running", 32'(bus.running), 32'd1);
        for (int i = 1; i <= 40; i++) begin
            drive_safe();
            @(negedge clk);
            if (i == 12) chk("t0_three_ticks", 32'(bus.timers[2:0]), 32'd2);
            if (i == 20) begin
                chk("elim_alive", 32'(bus.alive), 32'b110);
                chk("elim_active", 32'(bus.active), 32'd1);
            end
        end
        chk("over_alive", 32'(bus.alive), 32'b100);
        chk("over_flag", 32'(bus.game_over), 32'd1);
        chk("over_winner", 32'(bus.winner), 32'd2);
        bus.start = 1'b1;
        repeat (6) @(negedge clk);
        chk("over_holds", 32'(bus.game_over), 32'd1);
        chk("over_frozen_t2", 32'(bus.timers[8:6]), 32'd5);
        // Reset then a clean match and a non-active holder.
        reset = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        bus.start = 1'b1;
        drive_safe();
        @(negedge clk);
        bus.start = 1'b0;
        bus.player_in = {~m_tgt, m_tgt, ~m_tgt};
        @(negedge clk);
        chk("p1_hold_active", 32'(bus.active), 32'd0);
        chk("p1_hold_pulse", 32'(bus.match_pulse), 32'd0);
        old = m_tgt;
        bus.player_in = {~m_tgt, ~m_tgt, m_tgt};
        @(negedge clk);
        chk("match_pulse_lit", 32'(bus.match_pulse), 32'd1);
        chk("match_active", 32'(bus.active), 32'd1);
        chk("match_new_target", 32'(bus.target != old), 32'd1);
        chk("match_t0", 32'(bus.timers[2:0]), 32'd5);
        // Match on the exact tick cycle.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.start = 1'b1;
        drive_safe();
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            drive_safe();
            @(negedge clk);
        end
        chk("pre_tick_t0", 32'(bus.timers[2:0]), 32'd3);
        bus.player_in = {~m_tgt, ~m_tgt, m_tgt};
        @(negedge clk);
        chk("tick_match_t0", 32'(bus.timers[2:0]), (3 + BON > SS) ? SS : 3 + BON);
        chk("tick_match_active", 32'(bus.active), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            drive_safe();
            @(negedge clk);
        end
        chk("mid_t1", 32'(bus.timers[5:3]), 32'd4);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_timers", 32'(bus.timers), 32'({3{3'd5}}));
        chk("midrst_alive", 32'(bus.alive), 32'b111);
        chk("midrst_running", 32'(bus.running), 32'd0);
        // Randomized play with occasional resets.
        for (int i = 0; i < 6000; i++) begin
            reset = (m_phase == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 999) == 0;
            bus.start = $urandom_range(0, 3) == 0;
            bus.player_in = PIW'($urandom);
            if ($urandom_range(0, 5) == 0) bus.player_in[m_act*W +: W] = m_tgt;
            if ($urandom_range(0, 3) == 0) bus.player_in[((m_act + 1) % NP)*W +: W] = m_tgt;
            @(negedge clk);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
